// File: rtl/mux16_rr_arbiter_if.sv
// Bundle of the request, data, select and grant signals shared by the 16 source
// lanes, the round-robin arbiter and the single downstream consumer.
interface mux16_rr_arbiter_if;
  logic [15:0] req;
  logic [15:0] in;
  logic [3:0]  sel;
  logic [15:0] grant;
  logic        busy;
  logic        out;

  // Lane side: presents requests and data, observes the grant and the muxed bit.
  modport master (
    output req,
    output in,
    input  sel,
    input  grant,
    input  busy,
    input  out
  );

  // Arbiter side.
  modport slave (
    input  req,
    input  in,
    output sel,
    output grant,
    output busy,
    output out
  );
endinterface

// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter for a shared 16:1 single-bit mux: registers the winning
// select code, holds each grant for at most HOLD cycles, forwards in[sel].
module mux16_rr_arbiter #(
  parameter int HOLD = 4,
  parameter int CW   = 4
) (
  input  logic              clk,
  input  logic              rst,
  mux16_rr_arbiter_if.slave bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t          state, state_d;
  logic [3:0]      sel_q, sel_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy;
  logic            release_now;
  logic            found;
  logic [3:0]      winner;

  assign busy        = (state == GRANT);
  assign release_now = busy & (~bus.req[sel_q] | (cnt_q == CW'(HOLD - 1)));

  // Cyclic search starting just after the last winner; the last step (k=16)
  // lands on sel_q itself so a sole requester can be re-granted.
  always_comb begin
    logic [3:0] idx;
    found  = 1'b0;
    winner = sel_q;
    idx    = sel_q;
    for (int k = 1; k <= 16; k++) begin
      idx = sel_q + 4'(k);
      if (!found && bus.req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_d = state;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          sel_d   = winner;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (release_now) begin
          cnt_d = '0;
          if (found) begin
            sel_d = winner;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sel_q <= 4'hF;
      cnt_q <= '0;
    end else begin
      state <= state_d;
      sel_q <= sel_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.sel   = sel_q;
  assign bus.busy  = busy;
  assign bus.grant = busy ? (16'h0001 << sel_q) : 16'h0000;
  assign bus.out   = busy & bus.in[sel_q];

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Directed table-driven bench for mux16_rr_arbiter (HOLD=4) plus hand-written
// sequences for asynchronous reset mid-grant and a HOLD=1 instance.
module tb_mux16_rr_arbiter;

  logic clk;
  logic rst;

  mux16_rr_arbiter_if bus4 ();
  mux16_rr_arbiter_if bus1 ();

  mux16_rr_arbiter #(.HOLD(4), .CW(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
  mux16_rr_arbiter #(.HOLD(1), .CW(4)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit          do_rst;
    bit          tick;
    logic [15:0] req;
    logic [15:0] din;
    logic [3:0]  exp_sel;
    logic        exp_busy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit do_rst, input bit tick, input logic [15:0] req,
                     input logic [15:0] din, input logic [3:0] exp_sel, input logic exp_busy);
    vec_t v;
    v.do_rst   = do_rst;
    v.tick     = tick;
    v.req      = req;
    v.din      = din;
    v.exp_sel  = exp_sel;
    v.exp_busy = exp_busy;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic check_dut4(input string tag, input logic [3:0] exp_sel, input logic exp_busy);
    logic [15:0] exp_grant;
    logic        exp_out;
    exp_grant = exp_busy ? (16'h0001 << exp_sel) : 16'h0000;
    exp_out   = exp_busy & bus4.in[exp_sel];
    check({tag, ".sel"},   16'(bus4.sel),   16'(exp_sel));
    check({tag, ".busy"},  16'(bus4.busy),  16'(exp_busy));
    check({tag, ".grant"}, bus4.grant,      exp_grant);
    check({tag, ".out"},   16'(bus4.out),   16'(exp_out));
  endtask

  initial begin
    rst      = 1'b1;
    bus4.req = '0;
    bus4.in  = '0;
    bus1.req = '0;
    bus1.in  = '0;
    #1;
    check_dut4("reset_init", 4'hF, 1'b0);
    check("reset_init.sel1", 16'(bus1.sel), 16'h000F);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Sole requester on lane 0: granted, re-granted at HOLD expiry, busy never drops.
    add(1, 1, 16'h0001, 16'h3f0a, 4'd0, 1);
    for (int i = 0; i < 6; i++) add(0, 1, 16'h0001, 16'h3f0a, 4'd0, 1);
    add(0, 1, 16'h0001, 16'h3f0b, 4'd0, 1);

    // Three requesters, four cycles each, then back to lane 1.
    add(1, 1, 16'h1042, 16'h1002, 4'd1, 1);
    for (int i = 0; i < 3; i++) add(0, 1, 16'h1042, 16'h1002, 4'd1, 1);
    for (int i = 0; i < 4; i++) add(0, 1, 16'h1042, 16'h1002, 4'd6, 1);
    for (int i = 0; i < 3; i++) add(0, 1, 16'h1042, 16'h1002, 4'd12, 1);
    add(0, 1, 16'h1042, 16'h0042, 4'd12, 1);
    add(0, 1, 16'h1042, 16'h1002, 4'd1, 1);

    // Lane 1 drops early: still granted in the drop cycle, lane 6 follows with no gap,
    // then idle at lane 6's expiry with no requests.
    add(1, 1, 16'h0042, 16'h0040, 4'd1, 1);
    add(0, 1, 16'h0042, 16'h0040, 4'd1, 1);
    add(0, 0, 16'h0040, 16'h0040, 4'd1, 1);
    add(0, 1, 16'h0040, 16'h0040, 4'd6, 1);
    for (int i = 0; i < 3; i++) add(0, 1, 16'h0040, 16'h0040, 4'd6, 1);
    add(0, 1, 16'h0000, 16'h0040, 4'd6, 0);
    add(0, 1, 16'h0000, 16'h0040, 4'd6, 0);

    // Wrap from lane 15 to lane 0 and back.
    add(1, 1, 16'h8000, 16'h8000, 4'd15, 1);
    for (int i = 0; i < 3; i++) add(0, 1, 16'h8001, 16'h8000, 4'd15, 1);
    for (int i = 0; i < 4; i++) add(0, 1, 16'h8001, 16'h8000, 4'd0, 1);
    add(0, 1, 16'h8001, 16'h8000, 4'd15, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].do_rst) pulse_rst();
      bus4.req = vecs[i].req;
      bus4.in  = vecs[i].din;
      if (vecs[i].tick) tick();
      else #1;
      check_dut4($sformatf("vec%0d", i), vecs[i].exp_sel, vecs[i].exp_busy);
    end

    // Asynchronous reset in the middle of a lane-12 grant (cnt=2).
    pulse_rst();
    bus4.req = 16'h1000;
    bus4.in  = 16'h1000;
    tick();
    tick();
    tick();
    check_dut4("mid_grant", 4'd12, 1'b1);
    rst = 1'b1;
    #1;
    check_dut4("async_rst", 4'hF, 1'b0);
    bus4.req = 16'hFFFF;
    #1;
    rst = 1'b0;
    check_dut4("rst_release", 4'hF, 1'b0);
    tick();
    check_dut4("after_rst", 4'd0, 1'b1);

    // HOLD=1: per-cycle round robin between lanes 1 and 2.
    pulse_rst();
    bus1.req = 16'h0006;
    bus1.in  = 16'h0004;
    for (int i = 0; i < 4; i++) begin
      logic [3:0] exp_sel;
      exp_sel = (i % 2 == 0) ? 4'd1 : 4'd2;
      tick();
      check($sformatf("hold1_%0d.sel", i),   16'(bus1.sel),  16'(exp_sel));
      check($sformatf("hold1_%0d.busy", i),  16'(bus1.busy), 16'h0001);
      check($sformatf("hold1_%0d.grant", i), bus1.grant,     16'h0001 << exp_sel);
      check($sformatf("hold1_%0d.out", i),   16'(bus1.out),  16'(exp_sel == 4'd2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
